// File: rtl/pu_accum_pkg.sv
// Shared constants and helpers for the multi-channel accumulator processing unit.
// Attribute bit positions and signed range limits for a given word width.
package pu_accum_pkg;

    localparam int ATTR_INVALID  = 0;
    localparam int ATTR_OVERFLOW = 1;

    function automatic logic [63:0] signed_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] signed_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/pu_accum_alu.sv
// Combinational negate/add/overflow datapath shared by all accumulator channels.
// Define PU_ACCUM_BANK_SATURATE_EN to clamp overflowing results instead of wrapping.
module pu_accum_alu
    import pu_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  neg,
    input  logic                  init,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ovf
);

    localparam logic [DATA_WIDTH-1:0] MIN_VAL = DATA_WIDTH'(signed_min(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] op;
    logic [DATA_WIDTH-1:0] sum;
    logic                  neg_ovf;
    logic                  add_ovf;

`ifdef PU_ACCUM_BANK_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] MAX_VAL = DATA_WIDTH'(signed_max(DATA_WIDTH));

    // Exact sum at two extra bits so the clamp direction is never ambiguous.
    logic signed [DATA_WIDTH:0]   op_w;
    logic signed [DATA_WIDTH+1:0] acc_w;
    logic signed [DATA_WIDTH+1:0] sum_w;
`endif

    always_comb begin
        neg_ovf = neg && (data_in == MIN_VAL);
        op      = neg ? ('0 - data_in) : data_in;
        sum     = acc + op;
        add_ovf = (acc[DATA_WIDTH-1] == op[DATA_WIDTH-1]) &&
                  (sum[DATA_WIDTH-1] != acc[DATA_WIDTH-1]);
        ovf     = neg_ovf | (!init & add_ovf);

`ifdef PU_ACCUM_BANK_SATURATE_EN
        op_w  = neg ? -$signed({data_in[DATA_WIDTH-1], data_in})
                    :  $signed({data_in[DATA_WIDTH-1], data_in});
        acc_w = init ? '0 : $signed({{2{acc[DATA_WIDTH-1]}}, acc});
        sum_w = acc_w + $signed({op_w[DATA_WIDTH], op_w});
        if (sum_w > $signed({2'b00, MAX_VAL})) begin
            result = MAX_VAL;
        end else if (sum_w < $signed({2'b11, MIN_VAL})) begin
            result = MIN_VAL;
        end else begin
            result = sum_w[DATA_WIDTH-1:0];
        end
`else
        result = init ? op : sum;
`endif
    end

endmodule

// File: rtl/pu_accum_bank.sv
// Bank of CHANNELS signed accumulators with sticky overflow/invalid flags and a
// registered, zero-when-idle output. Optional clamp mode: PU_ACCUM_BANK_SATURATE_EN.
module pu_accum_bank
    import pu_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ATTR_WIDTH = 2,
    parameter int CHANNELS   = 4,
    parameter int CH_WIDTH   = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_WIDTH-1:0]   signal_ch,
    input  logic                  signal_load,
    input  logic                  signal_init,
    input  logic                  signal_neg,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out
);

    logic [DATA_WIDTH-1:0] acc_q [CHANNELS];
    logic [CHANNELS-1:0]   ovf_q;
    logic [CHANNELS-1:0]   inv_q;

    logic                  sel_hit;
    logic [DATA_WIDTH-1:0] sel_acc;
    logic [ATTR_WIDTH-1:0] sel_attr;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_ovf;
    logic                  unused_attr;

    assign unused_attr = ^attr_in[ATTR_WIDTH-1:1];

    // An index with no matching channel selects nothing and reads as zero.
    always_comb begin
        sel_hit  = 1'b0;
        sel_acc  = '0;
        sel_attr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (signal_ch == CH_WIDTH'(i)) begin
                sel_hit                 = 1'b1;
                sel_acc                 = acc_q[i];
                sel_attr[ATTR_OVERFLOW] = ovf_q[i];
                sel_attr[ATTR_INVALID]  = inv_q[i];
            end
        end
    end

    pu_accum_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .acc    (sel_acc),
        .data_in(data_in),
        .neg    (signal_neg),
        .init   (signal_init),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // Output captures the pre-update channel value; the update lands on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q    <= '0;
            inv_q    <= '0;
            data_out <= '0;
            attr_out <= '0;
        end else begin
            if (signal_oe && sel_hit) begin
                data_out <= sel_acc;
                attr_out <= sel_attr;
            end else begin
                data_out <= '0;
                attr_out <= '0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (signal_load && (signal_ch == CH_WIDTH'(i))) begin
                    acc_q[i] <= alu_result;
                    ovf_q[i] <= signal_init ? alu_ovf : (ovf_q[i] | alu_ovf);
                    inv_q[i] <= signal_init ? attr_in[ATTR_INVALID]
                                            : (inv_q[i] | attr_in[ATTR_INVALID]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pu_accum_bank.sv
// Directed self-checking bench for pu_accum_bank with hand-computed expectations.
module tb_pu_accum_bank;

    logic        clk;
    logic        rst;
    logic [1:0]  signal_ch;
    logic        signal_load;
    logic        signal_init;
    logic        signal_neg;
    logic [15:0] data_in;
    logic [1:0]  attr_in;
    logic        signal_oe;
    logic [15:0] data_out;
    logic [1:0]  attr_out;

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_v;

    pu_accum_bank #(
        .DATA_WIDTH(16),
        .ATTR_WIDTH(2),
        .CHANNELS  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_ch  (signal_ch),
        .signal_load(signal_load),
        .signal_init(signal_init),
        .signal_neg (signal_neg),
        .data_in    (data_in),
        .attr_in    (attr_in),
        .signal_oe  (signal_oe),
        .data_out   (data_out),
        .attr_out   (attr_out)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one command, let it take the next rising edge, then settle 1 time unit.
    task automatic cmd(input logic [1:0] ch, input logic load, input logic init,
                       input logic neg, input logic [15:0] data, input logic [1:0] attr,
                       input logic oe);
        signal_ch   = ch;
        signal_load = load;
        signal_init = init;
        signal_neg  = neg;
        data_in     = data;
        attr_in     = attr;
        signal_oe   = oe;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        cmd(2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        nop();
        nop();
        checks++;
        if ({attr_out, data_out} !== 18'h0) begin
            errors++;
            $display("FAIL reset_out: got %h want %h", {attr_out, data_out}, 18'h0);
        end
        rst = 1'b1;
        cmd(2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== 18'h0) begin
            errors++;
            $display("FAIL reset_oe_ch0: got %h want %h", {attr_out, data_out}, 18'h0);
        end
        nop();
        checks++;
        if ({attr_out, data_out} !== 18'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", {attr_out, data_out}, 18'h0);
        end
    endtask

    task automatic test_overflow();
        cmd(2'd1, 1'b1, 1'b1, 1'b0, 16'h7FFF, 2'b00, 1'b0);
        cmd(2'd1, 1'b1, 1'b1, 1'b0, 16'h7FFF, 2'b00, 1'b0);
        cmd(2'd1, 1'b1, 1'b0, 1'b0, 16'h0001, 2'b00, 1'b0);
        cmd(2'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
`ifdef PU_ACCUM_BANK_SATURATE_EN
        exp_v = {2'b10, 16'h7FFF};
`else
        exp_v = {2'b10, 16'h8000};
`endif
        checks++;
        if ({attr_out, data_out} !== exp_v) begin
            errors++;
            $display("FAIL ovf_add: got %h want %h", {attr_out, data_out}, exp_v);
        end
        nop();
        checks++;
        if ({attr_out, data_out} !== 18'h0) begin
            errors++;
            $display("FAIL ovf_idle: got %h want %h", {attr_out, data_out}, 18'h0);
        end
    endtask

    task automatic test_neg();
        cmd(2'd0, 1'b1, 1'b1, 1'b1, 16'h0002, 2'b00, 1'b0);
        cmd(2'd0, 1'b1, 1'b0, 1'b1, 16'h0003, 2'b00, 1'b0);
        cmd(2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== {2'b00, 16'hFFFB}) begin
            errors++;
            $display("FAIL neg_acc: got %h want %h", {attr_out, data_out}, {2'b00, 16'hFFFB});
        end
        cmd(2'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== 18'h0) begin
            errors++;
            $display("FAIL ch2_untouched: got %h want %h", {attr_out, data_out}, 18'h0);
        end
    endtask

    task automatic test_invalid();
        cmd(2'd3, 1'b1, 1'b1, 1'b0, 16'h0005, 2'b01, 1'b0);
        cmd(2'd3, 1'b1, 1'b0, 1'b0, 16'h0004, 2'b00, 1'b0);
        cmd(2'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== {2'b01, 16'h0009}) begin
            errors++;
            $display("FAIL inv_sticky: got %h want %h", {attr_out, data_out}, {2'b01, 16'h0009});
        end
        cmd(2'd3, 1'b1, 1'b1, 1'b0, 16'h0001, 2'b00, 1'b0);
        cmd(2'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== {2'b00, 16'h0001}) begin
            errors++;
            $display("FAIL inv_reinit: got %h want %h", {attr_out, data_out}, {2'b00, 16'h0001});
        end
        // Reading again must return the same value: oe does not clear.
        cmd(2'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== {2'b00, 16'h0001}) begin
            errors++;
            $display("FAIL oe_persist: got %h want %h", {attr_out, data_out}, {2'b00, 16'h0001});
        end
    endtask

    task automatic test_back_to_back();
        // ch0 holds 0xFFFB; load+oe in the same cycle reads the old value.
        exp_q.push_back({2'b00, 16'hFFFB});
        exp_q.push_back({2'b00, 16'h000B});
        cmd(2'd0, 1'b1, 1'b0, 1'b0, 16'h0010, 2'b00, 1'b1);
        exp_v = exp_q.pop_front();
        checks++;
        if ({attr_out, data_out} !== exp_v) begin
            errors++;
            $display("FAIL oe_pre_update: got %h want %h", {attr_out, data_out}, exp_v);
        end
        cmd(2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        exp_v = exp_q.pop_front();
        checks++;
        if ({attr_out, data_out} !== exp_v) begin
            errors++;
            $display("FAIL oe_post_update: got %h want %h", {attr_out, data_out}, exp_v);
        end
    endtask

    task automatic test_noop_and_neg_min();
        // init-only and neg-only commands must leave ch2 at zero.
        cmd(2'd2, 1'b0, 1'b1, 1'b0, 16'h0005, 2'b01, 1'b0);
        cmd(2'd2, 1'b0, 1'b0, 1'b1, 16'h0007, 2'b01, 1'b0);
        cmd(2'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== 18'h0) begin
            errors++;
            $display("FAIL noop_cmds: got %h want %h", {attr_out, data_out}, 18'h0);
        end
        cmd(2'd2, 1'b1, 1'b1, 1'b1, 16'h8000, 2'b00, 1'b0);
        cmd(2'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
`ifdef PU_ACCUM_BANK_SATURATE_EN
        exp_v = {2'b10, 16'h7FFF};
`else
        exp_v = {2'b10, 16'h8000};
`endif
        checks++;
        if ({attr_out, data_out} !== exp_v) begin
            errors++;
            $display("FAIL neg_min: got %h want %h", {attr_out, data_out}, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        cmd(2'd0, 1'b1, 1'b0, 1'b0, 16'h0001, 2'b00, 1'b0);
        rst = 1'b0;
        cmd(2'd0, 1'b1, 1'b0, 1'b0, 16'h0001, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== 18'h0) begin
            errors++;
            $display("FAIL rst_mid_out: got %h want %h", {attr_out, data_out}, 18'h0);
        end
        rst = 1'b1;
        cmd(2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== 18'h0) begin
            errors++;
            $display("FAIL rst_mid_ch0: got %h want %h", {attr_out, data_out}, 18'h0);
        end
        cmd(2'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        checks++;
        if ({attr_out, data_out} !== 18'h0) begin
            errors++;
            $display("FAIL rst_mid_ch1: got %h want %h", {attr_out, data_out}, 18'h0);
        end
    endtask

    initial begin
        rst         = 1'b0;
        signal_ch   = '0;
        signal_load = 1'b0;
        signal_init = 1'b0;
        signal_neg  = 1'b0;
        data_in     = '0;
        attr_in     = '0;
        signal_oe   = 1'b0;

        test_reset();
        test_overflow();
        test_neg();
        test_invalid();
        test_back_to_back();
        test_noop_and_neg_min();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
